cpu_control: RTL
================

# cpu_control

Multi-cycle controller for the 16-bit datapath. Fetches instructions from the unified memory into an internal instruction register and maintains the 8-bit program counter. It decodes each instruction and sequences the datapath's register-file, A/B/C/status load, mux-select and ALU controls through a Moore state machine. It also owns the memory command and address outputs.

## Interface
Parameters: none.

Clock and reset:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high

Memory side:
- read_data  in  16  memory read data, valid the cycle after mem_cmd=READ with a stable mem_addr
- C  in  16  datapath C register
- mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
- mem_addr  out  8  PC in fetch states, data_addr otherwise
- write_data  out  16  equals C

Datapath controls:
- readnum, writenum  out  3 each  register selects
- write, loada, loadb, loadc, loads  out  1 each  load enables
- asel  out  1  1 selects 16'h0000 as Ain
- bsel  out  1  1 selects sximm5 as Bin
- shift  out  2  shifter op
- ALUop  out  2  00 ADD, 01 SUB/CMP, 10 AND, 11 NOT B
- vsel  out  2  register-file write source: 3 mdata, 2 sximm8, 1 PC, 0 C
- sximm8  out  16  sign-extended IR[7:0]
- sximm5  out  16  sign-extended IR[4:0]
- PC  out  8  program counter

Status:
- halted  out  1  high in HALT state

## Operation
- IR fields:
  - opcode IR[15:13], op IR[12:11]
  - Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0]
- Decoded instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{sh}
  - 101/00 ADD, 101/01 CMP, 101/10 AND, 101/11 MVN
  - 011/00 LDR Rd,[Rn,#imm5]
  - 100/00 STR Rd,[Rn,#imm5]
  - 111/xx HALT
  - Any other encoding goes to HALT.
- Common fetch sequence: RST → IF1 → IF2 → UPDATE_PC → DECODE.
  - IF1: mem_cmd=READ, mem_addr=PC.
  - IF2: same outputs; IR←read_data at the end of the cycle.
  - UPDATE_PC: PC←PC+1, mod 256 (wraps 0xFF→0x00).
- Execute states (every listed output not named is 0):
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1, shift=sh. For STR, readnum=Rd and shift=00.
  - ALU: asel=0, bsel=0, ALUop=op, loadc=1. For CMP, loads=1 and loadc=0. For MOV reg, asel=1 and ALUop=00. For STR pass, asel=1 and shift=00.
  - ADDR: asel=0, bsel=1, ALUop=00, loadc=1.
  - LOAD_ADDR: data_addr←C[7:0].
  - WRITE_IMM: vsel=2, writenum=Rn, write=1.
  - WRITE_RD: vsel=0, writenum=Rd, write=1.
  - MEM_RD: mem_cmd=READ, mem_addr=data_addr.
  - MEM_WB: mem_cmd=READ, mem_addr=data_addr, vsel=3, writenum=Rd, write=1.
  - MEM_WR: mem_cmd=WRITE, mem_addr=data_addr.
- Execute paths (all return to IF1 at the end):
  - MOV imm: WRITE_IMM.
  - MOV reg, MVN: GET_B, ALU, WRITE_RD.
  - ADD, AND: GET_A, GET_B, ALU, WRITE_RD.
  - CMP: GET_A, GET_B, ALU.
  - LDR: GET_A, ADDR, LOAD_ADDR, MEM_RD, MEM_WB.
  - STR: GET_A, ADDR, LOAD_ADDR, GET_B, ALU(pass), MEM_WR.
- HALT is absorbing until reset.
  - mem_cmd=NONE, PC and IR frozen, halted=1.

## Timing
- All registers update on the rising clk edge. Outputs are Moore, decoded from state and IR; sximm8, sximm5 and PC are combinational from registers.
- Reset has priority over every state, including mid-instruction and HALT.
  - Next cycle: state=RST, PC=0x00, IR=0x0000, data_addr=0x00.
  - In RST all outputs are 0, mem_cmd=NONE, mem_addr=0x00, halted=0.
  - No register-file write or memory write can occur in the cycle after reset is sampled.
- Cycles from IF1 to the next IF1:
  - MOV imm 5
  - MOV reg, MVN, CMP 7
  - ADD, AND 8
  - LDR 9
  - STR 10
- write and mem_cmd=WRITE are each asserted for exactly one cycle per instruction.
- PC increments exactly once per fetched instruction, including HALT.
- PC is sampled for mem_addr only in IF1 and IF2.

## Test plan
- Reset, then MOV R0,#-5 (0xD0FB) at address 0:
  - IF1 at reset+1, with mem_addr=0x00 and mem_cmd=01.
  - At reset+5, write=1, vsel=2, writenum=0, sximm8=0xFFFB.
  - PC=0x01 from UPDATE_PC onward.
- ADD R2,R0,R1,LSL#1 (0xA049):
  - loada with readnum=0, then loadb with readnum=1 and shift=01.
  - Then ALUop=00 with loadc=1.
  - Then write=1, writenum=2, vsel=0.
  - Total 8 cycles.
- CMP R0,R1 (0xA801): ALU state has loads=1, loadc=0, ALUop=01; write never asserted; next state IF1.
- LDR R3,[R0,#2] (0x6062), with C driven to 0x0042 at LOAD_ADDR:
  - MEM_RD and MEM_WB both show mem_addr=0x42, mem_cmd=01.
  - MEM_WB has write=1, vsel=3, writenum=3.
- STR R3,[R1,#1] (0x8161), with C=0x0010 at LOAD_ADDR then C=0xBEEF after pass:
  - One MEM_WR cycle with mem_cmd=10, mem_addr=0x10, write_data=0xBEEF.
- HALT (0xE000) at PC=0xFF:
  - PC wraps to 0x00.
  - halted=1 and mem_cmd=00 held for 20+ cycles.
  - Separately, assert reset during ADD's ALU state: the next cycle is RST with PC=0x00, and no write occurs.

Source files
------------

// File: rtl/cpu_control.sv
// cpu_control: multi-cycle fetch/decode/execute sequencer for the 16-bit datapath.
// Owns PC, IR and the data address latch; all datapath controls are Moore outputs.
module cpu_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] read_data,
  input  logic [15:0] C,
  output logic [1:0]  mem_cmd,
  output logic [7:0]  mem_addr,
  output logic [15:0] write_data,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [1:0]  vsel,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [7:0]  PC,
  output logic        halted
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [3:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPC,
    S_DEC,
    S_GETA,
    S_GETB,
    S_ALU,
    S_ADDR,
    S_LADDR,
    S_WIMM,
    S_WRD,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    I_MOVI,
    I_MOVR,
    I_ALU,
    I_LDR,
    I_STR,
    I_HALT
  } ins_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  daddr_q, daddr_d;

  logic [2:0] opc;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;
  ins_e       ins;
  logic       is_cmp;
  logic       is_mvn;

  assign opc = ir_q[15:13];
  assign op  = ir_q[12:11];
  assign rn  = ir_q[10:8];
  assign rd  = ir_q[7:5];
  assign sh  = ir_q[4:3];
  assign rm  = ir_q[2:0];

  assign sximm8     = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5     = {{11{ir_q[4]}}, ir_q[4:0]};
  assign PC         = pc_q;
  assign write_data = C;

  // Unlisted encodings fall through to HALT
  always_comb begin
    ins = I_HALT;
    unique case (1'b1)
      (opc == 3'b110) && (op == 2'b10): ins = I_MOVI;
      (opc == 3'b110) && (op == 2'b00): ins = I_MOVR;
      (opc == 3'b101):                  ins = I_ALU;
      (opc == 3'b011) && (op == 2'b00): ins = I_LDR;
      (opc == 3'b100) && (op == 2'b00): ins = I_STR;
      default:                          ins = I_HALT;
    endcase
  end

  assign is_cmp = (ins == I_ALU) && (op == 2'b01);
  assign is_mvn = (ins == I_ALU) && (op == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      pc_q    <= 8'h00;
      ir_q    <= 16'h0000;
      daddr_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      daddr_q <= daddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    daddr_d = daddr_q;
    unique case (state_q)
      S_RST: state_d = S_IF1;
      S_IF1: state_d = S_IF2;
      S_IF2: begin
        ir_d    = read_data;
        state_d = S_UPC;
      end
      S_UPC: begin
        pc_d    = pc_q + 8'd1;
        state_d = S_DEC;
      end
      S_DEC: begin
        unique case (ins)
          I_MOVI:       state_d = S_WIMM;
          I_MOVR:       state_d = S_GETB;
          I_ALU:        state_d = is_mvn ? S_GETB : S_GETA;
          I_LDR, I_STR: state_d = S_GETA;
          default:      state_d = S_HALT;
        endcase
      end
      S_GETA: begin
        if ((ins == I_LDR) || (ins == I_STR)) state_d = S_ADDR;
        else state_d = S_GETB;
      end
      S_GETB: state_d = S_ALU;
      S_ALU: begin
        if (is_cmp) state_d = S_IF1;
        else if (ins == I_STR) state_d = S_MEMWR;
        else state_d = S_WRD;
      end
      S_ADDR: state_d = S_LADDR;
      S_LADDR: begin
        daddr_d = C[7:0];
        state_d = (ins == I_LDR) ? S_MEMRD : S_GETB;
      end
      S_MEMRD: state_d = S_MEMWB;
      S_MEMWB: state_d = S_IF1;
      S_MEMWR: state_d = S_IF1;
      S_WIMM:  state_d = S_IF1;
      S_WRD:   state_d = S_IF1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    mem_cmd  = CMD_NONE;
    mem_addr = daddr_q;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    vsel     = 2'b00;
    halted   = 1'b0;
    unique case (state_q)
      S_RST: mem_addr = 8'h00;
      S_IF1, S_IF2: begin
        mem_cmd  = CMD_READ;
        mem_addr = pc_q;
      end
      S_GETA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GETB: begin
        loadb = 1'b1;
        if (ins == I_STR) begin
          readnum = rd;
        end else begin
          readnum = rm;
          shift   = sh;
        end
      end
      S_ALU: begin
        ALUop = op;
        loadc = 1'b1;
        // MOV reg and the STR store-data pass both add B to a zeroed A
        if (is_cmp) begin
          loads = 1'b1;
          loadc = 1'b0;
        end else if ((ins == I_MOVR) || (ins == I_STR)) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_WIMM: begin
        vsel     = 2'd2;
        writenum = rn;
        write    = 1'b1;
      end
      S_WRD: begin
        writenum = rd;
        write    = 1'b1;
      end
      S_MEMRD: mem_cmd = CMD_READ;
      S_MEMWB: begin
        mem_cmd  = CMD_READ;
        vsel     = 2'd3;
        writenum = rd;
        write    = 1'b1;
      end
      S_MEMWR: mem_cmd = CMD_WRITE;
      S_HALT:  halted  = 1'b1;
      default: ;
    endcase
  end

endmodule
